// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scan sequencer for a 4x4 matrix keypad.
// Drives a one-hot column strobe and samples the row inputs through a
// 2-flop synchronizer. A press must be confirmed by a debounce period
// before it is accepted, and a release must also be debounced. Each
// accepted key is buffered in a small FIFO that is drained with a
// valid/ready handshake.
//
// Ports:
//   clk        system clock
//   n_reset    synchronous active-low reset
//   filas_raw  asynchronous row inputs, active-high, bit i = row i
//   columnas   one-hot column strobe, active-high, bit j = column j
//   key_valid  FIFO non-empty
//   key_code   FIFO head, code = 4*col + row (0 when empty)
//   key_ready  consumer accepts the head when key_valid && key_ready
//   key_count  current FIFO occupancy
//   overflow   sticky; set when an accepted key is dropped on a full FIFO
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_TICKS     = 27000,
    parameter int unsigned DEBOUNCE_TICKS = 135000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic [3:0]                  filas_raw,
    output logic [3:0]                  columnas,
    output logic                        key_valid,
    output logic [3:0]                  key_code,
    input  logic                        key_ready,
    output logic [$clog2(FIFO_DEPTH):0] key_count,
    output logic                        overflow
);

    localparam int unsigned CntMax = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    localparam logic [CntW-1:0]   ScanLast = CntW'(SCAN_TICKS - 1);
    localparam logic [CntW-1:0]   DebLast  = CntW'(DEBOUNCE_TICKS);
    localparam logic [CountW-1:0] FullCnt  = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StScan,
        StConfirm,
        StEmit,
        StWaitRelease
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        cand_col_q, cand_col_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [3:0]        filas_meta_q, filas_s_q;
    logic              push;

    logic [3:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic              overflow_q;

    // Exactly one row asserted is a valid press; anything else is either
    // idle or a ghosting pattern and is ignored.
    logic       press_ok;
    logic [1:0] press_row;

    always_comb begin
        press_ok  = 1'b0;
        press_row = 2'd0;
        case (filas_s_q)
            4'b0001: begin press_ok = 1'b1; press_row = 2'd0; end
            4'b0010: begin press_ok = 1'b1; press_row = 2'd1; end
            4'b0100: begin press_ok = 1'b1; press_row = 2'd2; end
            4'b1000: begin press_ok = 1'b1; press_row = 2'd3; end
            default: begin press_ok = 1'b0; press_row = 2'd0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        push       = 1'b0;
        case (state_q)
            StScan: begin
                if (cnt_q == ScanLast) begin
                    cnt_d = '0;
                    if (press_ok) begin
                        cand_col_d = col_q;
                        cand_row_d = press_row;
                        state_d    = StConfirm;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StConfirm: begin
                if (!press_ok || (press_row != cand_row_q)) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = StScan;
                end else if (cnt_q == DebLast) begin
                    cnt_d   = '0;
                    state_d = StEmit;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StEmit: begin
                push    = 1'b1;
                cnt_d   = '0;
                state_d = StWaitRelease;
            end
            StWaitRelease: begin
                // Any row activity restarts the release debounce.
                if (filas_s_q != 4'b0000) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    cnt_d   = '0;
                    col_d   = cand_col_q + 2'd1;
                    state_d = StScan;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StScan;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            filas_meta_q <= 4'b0000;
            filas_s_q    <= 4'b0000;
            state_q      <= StScan;
            cnt_q        <= '0;
            col_q        <= 2'd0;
            cand_col_q   <= 2'd0;
            cand_row_q   <= 2'd0;
        end else begin
            filas_meta_q <= filas_raw;
            filas_s_q    <= filas_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            cand_col_q   <= cand_col_d;
            cand_row_q   <= cand_row_d;
        end
    end

    // A pop in the same cycle frees a slot, so a push onto a full FIFO is
    // still accepted when the consumer drains the head simultaneously.
    logic pop, full, push_ok, drop;

    always_comb begin
        pop     = (count_q != '0) && key_ready;
        full    = (count_q == FullCnt);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 4'h0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {cand_col_q, cand_row_q};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CountW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        columnas  = 4'b0001 << col_q;
        key_valid = (count_q != '0);
        key_code  = key_valid ? mem_q[rd_ptr_q] : 4'h0;
        key_count = count_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_TICKS=8, DEBOUNCE_TICKS=4,
// FIFO_DEPTH=4). A physical keypad model maps pressed keys onto row lines
// through the active column; a queue tracks the keys the FIFO should hold.
module tb_keypad_scan_ctrl;

    localparam int unsigned ScanTicks = 8;
    localparam int unsigned DebTicks  = 4;
    localparam int unsigned Depth     = 4;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [2:0] key_count;
    logic       overflow;

    logic [15:0] keys;          // key index = 4*col + row
    logic [3:0]  model_q [$];
    logic        model_ovf;
    int          n_checks = 0;
    int          n_pass   = 0;

    keypad_scan_ctrl #(
        .SCAN_TICKS     (ScanTicks),
        .DEBOUNCE_TICKS (DebTicks),
        .FIFO_DEPTH     (Depth)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .filas_raw (filas_raw),
        .columnas  (columnas),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_count (key_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // A row reads high when any pressed key on it sits in a driven column.
    always_comb begin
        filas_raw = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[4*c+r] && columnas[c]) filas_raw[r] = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    // Press one key long enough for any scan phase to catch it, then release.
    task automatic do_press(input logic [3:0] code);
        int         hold;
        logic [3:0] exp_col;
        keys = '0;
        keys[code] = 1'b1;
        hold = 50 + int'($urandom_range(0, 30));
        repeat (hold) tick();
        if (model_q.size() < Depth) model_q.push_back(code);
        else model_ovf = 1'b1;
        exp_col = 4'b0001 << code[3:2];
        n_checks++;
        if (key_count !== 3'(model_q.size()))
            $display("FAIL press_count code=%h got %0d want %0d", code, key_count, model_q.size());
        else n_pass++;
        n_checks++;
        if (key_code !== model_q[0])
            $display("FAIL press_head code=%h got %h want %h", code, key_code, model_q[0]);
        else n_pass++;
        n_checks++;
        if (overflow !== model_ovf)
            $display("FAIL press_ovf code=%h got %b want %b", code, overflow, model_ovf);
        else n_pass++;
        n_checks++;
        if (columnas !== exp_col)
            $display("FAIL press_hold_col code=%h got %b want %b", code, columnas, exp_col);
        else n_pass++;
        keys = '0;
        repeat (20) tick();
    endtask

    task automatic test_reset_and_scan();
        logic [3:0] exp_col;
        keys = '0;
        key_ready = 1'b0;
        apply_reset();
        n_checks++;
        if ({key_valid, key_count, key_code, overflow} !== 9'b0)
            $display("FAIL reset_outputs got v=%b n=%0d c=%h o=%b want all 0",
                     key_valid, key_count, key_code, overflow);
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick();
            exp_col = 4'b0001 << ((k / ScanTicks) % 4);
            n_checks++;
            if (columnas !== exp_col)
                $display("FAIL scan_rotation k=%0d got %b want %b", k, columnas, exp_col);
            else n_pass++;
        end
        n_checks++;
        if (key_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL scan_idle got v=%b o=%b want 0 0", key_valid, overflow);
        else n_pass++;
    endtask

    // Key at col 1 row 2: sampled at edge 16, visible after edge 16+D+2.
    task automatic test_single_press();
        keys = '0;
        keys[6] = 1'b1;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 21) begin
                n_checks++;
                if (key_valid !== 1'b0) $display("FAIL latency_early got %b want 0", key_valid);
                else n_pass++;
            end
            if (k == 22) begin
                n_checks++;
                if (key_valid !== 1'b1 || key_code !== 4'h6 || key_count !== 3'd1)
                    $display("FAIL latency_key got v=%b c=%h n=%0d want 1 6 1",
                             key_valid, key_code, key_count);
                else n_pass++;
            end
            if (k >= 8) begin
                n_checks++;
                if (columnas !== 4'b0010)
                    $display("FAIL press_hold k=%0d got %b want 0010", k, columnas);
                else n_pass++;
            end
        end
        n_checks++;
        if (key_count !== 3'd1) $display("FAIL no_repeat got %0d want 1", key_count);
        else n_pass++;
        keys = '0;
        for (int k = 41; k <= 47; k++) begin
            tick();
            if (k == 46) begin
                n_checks++;
                if (columnas !== 4'b0010)
                    $display("FAIL release_hold got %b want 0010", columnas);
                else n_pass++;
            end
            if (k == 47) begin
                n_checks++;
                if (columnas !== 4'b0100)
                    $display("FAIL release_resume got %b want 0100", columnas);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bounce();
        keys = '0;
        keys[0] = 1'b1;
        apply_reset();
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 9) begin
                n_checks++;
                if (columnas !== 4'b0001)
                    $display("FAIL bounce_confirm got %b want 0001", columnas);
                else n_pass++;
                keys = '0;
            end
            if (k == 11 || k == 12 || k == 19 || k == 20) begin
                logic [3:0] exp_col;
                exp_col = (k == 11) ? 4'b0001 : (k == 20) ? 4'b0100 : 4'b0010;
                n_checks++;
                if (columnas !== exp_col)
                    $display("FAIL bounce_col k=%0d got %b want %b", k, columnas, exp_col);
                else n_pass++;
            end
        end
        n_checks++;
        if (key_count !== 3'd0 || key_valid !== 1'b0)
            $display("FAIL bounce_nopush got n=%0d v=%b want 0 0", key_count, key_valid);
        else n_pass++;
    endtask

    task automatic test_ghosting();
        keys = '0;
        keys[8] = 1'b1;
        keys[9] = 1'b1;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 24) begin
                n_checks++;
                if (columnas !== 4'b1000) $display("FAIL ghost_skip got %b want 1000", columnas);
                else n_pass++;
            end
            if (k == 32) begin
                n_checks++;
                if (columnas !== 4'b0001) $display("FAIL ghost_wrap got %b want 0001", columnas);
                else n_pass++;
            end
        end
        n_checks++;
        if (key_count !== 3'd0) $display("FAIL ghost_nopush got %0d want 0", key_count);
        else n_pass++;
        keys = '0;
        repeat (10) tick();
    endtask

    task automatic test_overflow();
        logic [3:0] codes [5];
        codes[0] = 4'h0; codes[1] = 4'h5; codes[2] = 4'hA; codes[3] = 4'hF; codes[4] = 4'h3;
        apply_reset();
        for (int i = 0; i < 5; i++) do_press(codes[i]);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (key_valid !== 1'b1 || key_code !== model_q[0])
                $display("FAIL drain_order i=%0d got v=%b c=%h want 1 %h",
                         i, key_valid, key_code, model_q[0]);
            else n_pass++;
            tick();
            void'(model_q.pop_front());
        end
        key_ready = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || key_count !== 3'd0 || key_code !== 4'h0 || overflow !== 1'b1)
            $display("FAIL drain_empty got v=%b n=%0d c=%h o=%b want 0 0 0 1",
                     key_valid, key_count, key_code, overflow);
        else n_pass++;
    endtask

    // Fill the FIFO, then pop exactly on the EMIT cycle of a fifth press.
    task automatic test_back_to_back();
        logic [3:0] prev;
        bit         found;
        apply_reset();
        do_press(4'h0);
        do_press(4'h5);
        do_press(4'hA);
        do_press(4'hF);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            prev = columnas;
            tick();
            if (columnas == 4'b1000 && prev != 4'b1000) found = 1;
        end
        keys = '0;
        keys[3] = 1'b1;
        if (found) begin
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                prev = columnas;
                tick();
                if (columnas == 4'b0001 && prev != 4'b0001) found = 1;
            end
        end
        n_checks++;
        if (!found) $display("FAIL emit_align got no column phase want 1000->0001");
        else n_pass++;
        repeat (8) tick();
        n_checks++;
        if (columnas !== 4'b0001) $display("FAIL emit_confirm got %b want 0001", columnas);
        else n_pass++;
        repeat (5) tick();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(4'h3);
        repeat (3) tick();
        n_checks++;
        if (key_count !== 3'(model_q.size()) || overflow !== 1'b0 || key_code !== model_q[0])
            $display("FAIL emit_pop got n=%0d o=%b c=%h want %0d 0 %h",
                     key_count, overflow, key_code, model_q.size(), model_q[0]);
        else n_pass++;
        keys = '0;
        repeat (20) tick();
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (key_code !== model_q[0])
                $display("FAIL emit_drain i=%0d got %h want %h", i, key_code, model_q[0]);
            else n_pass++;
            tick();
            void'(model_q.pop_front());
        end
        key_ready = 1'b0;
    endtask

    task automatic test_random_traffic();
        int  guard;
        bit  r;
        apply_reset();
        for (int round = 0; round < 3; round++) begin
            for (int j = 0; j < 3; j++) do_press(4'($urandom_range(0, 15)));
            guard = 0;
            while (model_q.size() != 0 && guard < 200) begin
                r = 1'($urandom_range(0, 1));
                key_ready = r;
                n_checks++;
                if (key_valid !== 1'b1 || key_code !== model_q[0] ||
                    key_count !== 3'(model_q.size()))
                    $display("FAIL rand_head got v=%b c=%h n=%0d want 1 %h %0d",
                             key_valid, key_code, key_count, model_q[0], model_q.size());
                else n_pass++;
                tick();
                if (r) void'(model_q.pop_front());
                guard++;
            end
            key_ready = 1'b0;
            n_checks++;
            if (key_valid !== 1'b0 || key_count !== 3'd0)
                $display("FAIL rand_empty got v=%b n=%0d want 0 0", key_valid, key_count);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        bit found;
        apply_reset();
        do_press(4'h2);
        keys = '0;
        keys[5] = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (key_count == 3'd2) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL midrst_setup got %0d want 2", key_count);
        else n_pass++;
        repeat (3) tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        n_checks++;
        if (key_count !== 3'd0 || key_valid !== 1'b0 || columnas !== 4'b0001 ||
            key_code !== 4'h0 || overflow !== 1'b0)
            $display("FAIL midrst_state got n=%0d v=%b col=%b c=%h o=%b want 0 0 0001 0 0",
                     key_count, key_valid, columnas, key_code, overflow);
        else n_pass++;
        repeat (7) tick();
        n_checks++;
        if (columnas !== 4'b0001) $display("FAIL midrst_scan0 got %b want 0001", columnas);
        else n_pass++;
        tick();
        n_checks++;
        if (columnas !== 4'b0010) $display("FAIL midrst_scan1 got %b want 0010", columnas);
        else n_pass++;
        keys = '0;
        repeat (30) tick();
    endtask

    initial begin
        n_reset   = 1'b0;
        key_ready = 1'b0;
        keys      = '0;
        model_ovf = 1'b0;
        test_reset_and_scan();
        test_single_press();
        test_bounce();
        test_ghosting();
        test_overflow();
        test_back_to_back();
        test_random_traffic();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencer for the 4x4 matrix keypad datapath. It drives the one-hot column strobe, samples the row inputs, and debounces a press before accepting it. Each accepted key is encoded and buffered in a small FIFO, which the downstream logic drains with a valid/ready handshake. It sits between the keypad pins and the key-consumer logic, and owns column timing and the press/release policy.

Parameters:
SCAN_TICKS, 27000, clk cycles each column stays active in SCAN (about 1 ms at 27 MHz); must be >= 4
DEBOUNCE_TICKS, 135000, consecutive stable cycles required to confirm a press and to confirm a release; must be >= 1
FIFO_DEPTH, 4, key FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
n_reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
filas_raw  input  4  asynchronous row inputs, active-high; bit i = row i
columnas  output  4  one-hot column strobe, active-high; bit j = column j
key_valid  output  1  FIFO non-empty
key_code  output  4  FIFO head; code = 4*col + row
key_ready  input  1  consumer accepts the head when key_valid && key_ready
key_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky flag; set when an accepted key is dropped because the FIFO is full

Behaviour:
- Reset (n_reset=0 at a clk edge) applies to all state:
  - columnas=4'b0001, key_valid=0, key_code=0, key_count=0, overflow=0
  - FSM=SCAN, tick counter=0, synchronizer flops=0, FIFO pointers=0
  - Reset mid-operation discards the FIFO contents and any pending candidate.
- Input sync: filas_raw passes through a 2-flop synchronizer to give filas_s. All decisions use filas_s, so there are 2 cycles of input latency.
- Row decode: a press is valid only when filas_s has exactly one bit set; row = that bit's index. Zero bits or two or more bits count as "no valid press" (ghosting rejection).
- SCAN state:
  - The tick counter counts 0..SCAN_TICKS-1 while the current column is driven.
  - On the last tick, if filas_s holds a valid press: latch cand_col = active column index and cand_row = decoded row, clear the counter, go to CONFIRM. columnas stays on the same column.
  - Otherwise, rotate columnas left (4'b1000 wraps to 4'b0001) and clear the counter.
- CONFIRM state:
  - Each cycle, if filas_s is not a valid press or its row differs from cand_row, clear the counter, rotate columnas, and return to SCAN.
  - Otherwise, increment the counter. When it reaches DEBOUNCE_TICKS, go to EMIT.
- EMIT state (exactly 1 cycle):
  - Push code {cand_col[1:0], cand_row[1:0]}.
  - If the FIFO is full and no pop occurs this cycle, drop the code and set overflow=1.
  - Then go to WAIT_RELEASE with the counter cleared.
- WAIT_RELEASE state:
  - columnas stays held on cand_col.
  - Each cycle: if filas_s==0, increment the counter; otherwise clear it.
  - When the counter reaches DEBOUNCE_TICKS, rotate columnas and return to SCAN with the counter cleared. One press produces exactly one key.
- FIFO behaviour:
  - key_valid = (count != 0); key_code = mem[rd_ptr], and holds its value while key_valid && !key_ready.
  - Pop when key_valid && key_ready.
  - A push and pop in the same cycle leave count unchanged, including when full (the push is accepted) and when empty (no pop occurs, push only).
  - Pointers wrap modulo FIFO_DEPTH.
  - key_code is 0 when the FIFO is empty.
- overflow is cleared only by reset.
- Latency: a key is held stable across the SCAN sample point. key_valid rises DEBOUNCE_TICKS+2 cycles after that sample edge (CONFIRM, then EMIT, then registered FIFO count).

Test Plan:
(Parameters SCAN_TICKS=8, DEBOUNCE_TICKS=4, FIFO_DEPTH=4; key_ready=0 unless stated.)
1. Reset and scan rotation: hold n_reset=0 for 3 cycles, then release with filas_raw=0 -> columnas=0001, 0010, 0100, 1000, 0001, each held exactly 8 cycles; key_valid=0; overflow=0.
2. Single press: filas_raw=4'b0100 held while columnas=0010 until its sample point and for 10 more cycles, then released -> exactly one key_code=4'h6, key_valid=1, key_count=1; no second push while held; scanning resumes after 4 cycles of release.
3. Bounce rejection: filas_raw=4'b0001 during column 0, dropped to 0 two cycles into CONFIRM -> no push, key_count=0, columnas advances to 0010.
4. Ghosting: filas_raw=4'b0011 during any column -> no CONFIRM entry, no push.
5. FIFO full/overflow: five confirmed presses, codes 0, 5, A, F, 3, with key_ready=0 -> key_count=4, overflow=1, head=0. Then assert key_ready for 4 cycles -> codes 0, 5, A, F pop in order and key_valid=0. Repeat with key_ready=1 on the EMIT cycle of the fifth press -> push accepted, overflow stays 0.
6. Reset mid-operation: n_reset=0 while in WAIT_RELEASE with key_count=2 -> next cycle key_count=0, key_valid=0, columnas=0001, FSM in SCAN.
